// File: rtl/life_board.sv
// Game of Life board: double-banked COLS x ROWS grid, B3/S23 generation one row per cycle,
// and registered VGA pixel colour. Define LIFE_GRIDLINES_EN to draw blue cell borders.
module life_board #(
    parameter int          COLS       = 20,
    parameter int          ROWS       = 15,
    parameter int          CELL_SHIFT = 5,
    parameter int          WRAP       = 1,
    parameter logic [2:0]  ALIVE_RGB  = 3'b111,
    parameter logic [2:0]  DEAD_RGB   = 3'b000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [9:0]      x,
    input  logic [9:0]      y,
    output logic [2:0]      rgb,
    input  logic            wr_en,
    input  logic [4:0]      wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            step,
    output logic            busy,
    output logic            done,
    output logic [15:0]     gen_count
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, CALC, SWAP} state_t;

    state_t          state_r, state_s;
    logic [RW-1:0]   r_r;
    logic            sel_r;
    logic            busy_r;
    logic            done_r;
    logic [15:0]     gen_count_r;
    logic [2:0]      rgb_r;

    logic [COLS-1:0] bank0_r [ROWS];
    logic [COLS-1:0] bank1_r [ROWS];
    logic [COLS-1:0] cur_rows_s [ROWS];

    logic [COLS-1:0] up_s, mid_s, dn_s, next_row_s;
    logic            wr_ok_s;
    logic [9:0]      disp_col_s, disp_row_s;
    logic            in_grid_s;
    logic [COLS-1:0] row_bits_s;
    logic            cell_s;
    logic [2:0]      pix_s;

    // Neighbour from column c-1 moved into position c; the edge column wraps or reads dead.
    function automatic logic [COLS-1:0] from_west(input logic [COLS-1:0] v);
        logic [COLS-1:0] o;
        o    = v << 1;
        o[0] = (WRAP != 0) ? v[COLS-1] : 1'b0;
        return o;
    endfunction

    // Neighbour from column c+1 moved into position c.
    function automatic logic [COLS-1:0] from_east(input logic [COLS-1:0] v);
        logic [COLS-1:0] o;
        o         = v >> 1;
        o[COLS-1] = (WRAP != 0) ? v[0] : 1'b0;
        return o;
    endfunction

    assign rgb       = rgb_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign gen_count = gen_count_r;

    // Current-bank view shared by display, writes and the generation engine.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            cur_rows_s[i] = sel_r ? bank1_r[i] : bank0_r[i];
        end
    end

    // Rows r-1, r, r+1 of the current bank for the row being computed.
    always_comb begin
        mid_s = cur_rows_s[r_r];
        if (r_r == LAST_ROW) begin
            dn_s = (WRAP != 0) ? cur_rows_s[0] : '0;
        end else begin
            dn_s = cur_rows_s[r_r + RW'(1)];
        end
        if (r_r == RW'(0)) begin
            up_s = (WRAP != 0) ? cur_rows_s[LAST_ROW] : '0;
        end else begin
            up_s = cur_rows_s[r_r - RW'(1)];
        end
    end

    // B3/S23 rule for every column of the current row in parallel.
    always_comb begin
        logic [COLS-1:0] uw, ue, mw, me, dw, de;
        logic [3:0]      cnt;
        uw = from_west(up_s);
        ue = from_east(up_s);
        mw = from_west(mid_s);
        me = from_east(mid_s);
        dw = from_west(dn_s);
        de = from_east(dn_s);
        cnt = 4'd0;
        next_row_s = '0;
        for (int c = 0; c < COLS; c++) begin
            cnt = 4'(uw[c]) + 4'(up_s[c]) + 4'(ue[c]) + 4'(mw[c]) + 4'(me[c])
                + 4'(dw[c]) + 4'(dn_s[c]) + 4'(de[c]);
            next_row_s[c] = (cnt == 4'd3) || ((cnt == 4'd2) && mid_s[c]);
        end
    end

    // Next-state logic for IDLE -> CALC -> SWAP -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (step) state_s = CALC;
                else      state_s = IDLE;
            end
            CALC: begin
                if (r_r == LAST_ROW) state_s = SWAP;
                else                 state_s = CALC;
            end
            SWAP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Control registers: state, row counter, bank select, status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            r_r         <= '0;
            sel_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            gen_count_r <= 16'd0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_r == SWAP);
            if (state_r == CALC && r_r != LAST_ROW) r_r <= r_r + RW'(1);
            else                                    r_r <= '0;
            if (state_r == SWAP) begin
                sel_r       <= ~sel_r;
                gen_count_r <= gen_count_r + 16'd1;
            end
        end
    end

    assign wr_ok_s = ({1'b0, wr_row} < 6'(ROWS));

    // Cell storage: loader writes hit the current bank, the engine fills the other one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                bank0_r[i] <= '0;
                bank1_r[i] <= '0;
            end
        end else if (state_r == IDLE && wr_en && wr_ok_s) begin
            if (sel_r) bank1_r[wr_row[RW-1:0]] <= wr_data;
            else       bank0_r[wr_row[RW-1:0]] <= wr_data;
        end else if (state_r == CALC) begin
            if (sel_r) bank0_r[r_r] <= next_row_s;
            else       bank1_r[r_r] <= next_row_s;
        end
    end

    assign disp_col_s = x >> CELL_SHIFT;
    assign disp_row_s = y >> CELL_SHIFT;
    assign in_grid_s  = (disp_col_s < 10'(COLS)) && (disp_row_s < 10'(ROWS));

    // Pixel colour lookup for the current bank.
    always_comb begin
        row_bits_s = '0;
        cell_s     = 1'b0;
        pix_s      = DEAD_RGB;
        if (in_grid_s) begin
            row_bits_s = cur_rows_s[disp_row_s[RW-1:0]];
            cell_s     = row_bits_s[disp_col_s[CW-1:0]];
`ifdef LIFE_GRIDLINES_EN
            if (x[CELL_SHIFT-1:0] == '0 || y[CELL_SHIFT-1:0] == '0) begin
                pix_s = 3'b001;
            end else begin
                pix_s = cell_s ? ALIVE_RGB : DEAD_RGB;
            end
`else
            pix_s = cell_s ? ALIVE_RGB : DEAD_RGB;
`endif
        end else begin
            pix_s = DEAD_RGB;
        end
    end

    // Registered colour output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgb_r <= 3'b000;
        else        rgb_r <= pix_s;
    end

endmodule

// File: tb/tb_life_board.sv
// Self-checking bench for life_board: a wrapping and a non-wrapping board share stimulus
// and are compared against a neighbour-counting reference model.
module tb_life_board;

    localparam int COLS = 20;
    localparam int ROWS = 15;

    typedef logic [COLS-1:0] grid_t [ROWS];

    logic            clk = 1'b0;
    logic            rst_n;
    logic [9:0]      x, y;
    logic            wr_en;
    logic [4:0]      wr_row;
    logic [COLS-1:0] wr_data;
    logic            step;
    logic [2:0]      rgb, rgb_nw;
    logic            busy, busy_nw, done, done_nw;
    logic [15:0]     gen_count, gen_count_nw;

    int n_checks = 0;
    int n_fail   = 0;
    grid_t mw, mn, sw, sn;
    logic [15:0] exp_gen;

    always #5 clk = ~clk;

    life_board dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .rgb(rgb),
        .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .step(step),
        .busy(busy), .done(done), .gen_count(gen_count)
    );

    life_board #(.WRAP(0)) dut_nw (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .rgb(rgb_nw),
        .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .step(step),
        .busy(busy_nw), .done(done_nw), .gen_count(gen_count_nw)
    );

    // Reference generation: count the eight neighbours of every cell directly.
    task automatic life_next(input grid_t g, input int wrap, output grid_t n);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int cnt;
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr, cc;
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap != 0) begin
                            rr = (rr + ROWS) % ROWS;
                            cc = (cc + COLS) % COLS;
                            cnt += int'(g[rr][cc]);
                        end else if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                            cnt += int'(g[rr][cc]);
                        end
                    end
                end
                n[r][c] = (cnt == 3) || (cnt == 2 && g[r][c]);
            end
        end
    endtask

    task automatic model_step();
        grid_t t;
        life_next(mw, 1, t); mw = t;
        life_next(mn, 0, t); mn = t;
        exp_gen = exp_gen + 16'd1;
    endtask

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++) begin
            mw[r] = '0;
            mn[r] = '0;
        end
        exp_gen = 16'd0;
    endtask

    task automatic write_row(input int r, input logic [COLS-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_row = 5'(r); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (r < ROWS) begin
            mw[r] = d;
            mn[r] = d;
        end
    endtask

    task automatic clear_grid();
        for (int r = 0; r < ROWS; r++) write_row(r, '0);
    endtask

    task automatic rand_grid();
        for (int r = 0; r < ROWS; r++) write_row(r, COLS'($urandom()) & COLS'($urandom() | $urandom()));
    endtask

    // Pulse step, then watch busy/done for a fixed window; k = 0 is the cycle after acceptance.
    task automatic step_watch(output int busy_cycles, output int done_cycle, output int pulses);
        busy_cycles = 0; done_cycle = -1; pulses = 0;
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_cycles++;
            if (done) begin
                pulses++;
                if (done_cycle < 0) done_cycle = k;
            end
            @(negedge clk);
        end
        model_step();
    endtask

    task automatic scan();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                @(negedge clk);
                x = 10'(c * 32 + 16);
                y = 10'(r * 32 + 16);
                @(negedge clk);
                sw[r][c] = (rgb == 3'b111) ? 1'b1 : (rgb == 3'b000) ? 1'b0 : 1'bx;
                sn[r][c] = (rgb_nw == 3'b111) ? 1'b1 : (rgb_nw == 3'b000) ? 1'b0 : 1'bx;
            end
        end
    endtask

    task automatic test_reset();
        rand_grid();
        @(negedge clk); x = 10'd100; y = 10'd70;
        @(negedge clk); rst_n = 1'b0;
        #1;
        n_checks++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL reset_rgb: got %b expected 000", rgb); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (gen_count !== 16'd0) begin n_fail++; $display("FAIL reset_gen: got %0d expected 0", gen_count); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        scan();
        for (int r = 0; r < ROWS; r++) begin
            n_checks++; if (sw[r] !== '0) begin n_fail++; $display("FAIL reset_grid row %0d: got %h expected 0", r, sw[r]); end
        end
    endtask

    task automatic test_blinker();
        int bc, dc, np;
        clear_grid();
        write_row(6, 20'h00070);
        step_watch(bc, dc, np);
        n_checks++; if (bc != ROWS + 1) begin n_fail++; $display("FAIL blinker_busy_cycles: got %0d expected %0d", bc, ROWS + 1); end
        n_checks++; if (dc != ROWS + 1) begin n_fail++; $display("FAIL blinker_done_cycle: got %0d expected %0d", dc, ROWS + 1); end
        n_checks++; if (np != 1) begin n_fail++; $display("FAIL blinker_done_pulses: got %0d expected 1", np); end
        n_checks++; if (gen_count !== 16'd1) begin n_fail++; $display("FAIL blinker_gen1: got %0d expected 1", gen_count); end
        scan();
        for (int r = 5; r <= 7; r++) begin
            n_checks++; if (sw[r] !== 20'h00020) begin n_fail++; $display("FAIL blinker_vertical row %0d: got %h expected 00020", r, sw[r]); end
        end
        step_watch(bc, dc, np);
        scan();
        n_checks++; if (sw[6] !== 20'h00070) begin n_fail++; $display("FAIL blinker_restore: got %h expected 00070", sw[6]); end
        n_checks++; if (sw[5] !== 20'h0) begin n_fail++; $display("FAIL blinker_row5: got %h expected 0", sw[5]); end
        n_checks++; if (gen_count !== 16'd2) begin n_fail++; $display("FAIL blinker_gen2: got %0d expected 2", gen_count); end
        for (int r = 0; r < ROWS; r++) begin
            n_checks++; if (sn[r] !== mn[r]) begin n_fail++; $display("FAIL blinker_nowrap row %0d: got %h expected %h", r, sn[r], mn[r]); end
        end
    endtask

    task automatic test_wrap();
        int bc, dc, np;
        clear_grid();
        write_row(0, 20'h80001);
        write_row(ROWS - 1, 20'h80001);
        step_watch(bc, dc, np);
        scan();
        for (int r = 0; r < ROWS; r++) begin
            n_checks++; if (sw[r] !== mw[r]) begin n_fail++; $display("FAIL wrap_model row %0d: got %h expected %h", r, sw[r], mw[r]); end
            n_checks++; if (sn[r] !== '0) begin n_fail++; $display("FAIL nowrap_dead row %0d: got %h expected 0", r, sn[r]); end
        end
        n_checks++; if (sw[0] !== 20'h80001 || sw[ROWS-1] !== 20'h80001) begin
            n_fail++; $display("FAIL wrap_block_stable: got %h/%h expected 80001/80001", sw[0], sw[ROWS-1]);
        end
    endtask

    task automatic test_display();
        logic [2:0] corner_exp;
        clear_grid();
        write_row(2, 20'h00008);
`ifdef LIFE_GRIDLINES_EN
        corner_exp = 3'b001;
`else
        corner_exp = 3'b111;
`endif
        @(negedge clk); x = 10'd100; y = 10'd70;
        @(negedge clk);
        n_checks++; if (rgb !== 3'b111) begin n_fail++; $display("FAIL disp_alive: got %b expected 111", rgb); end
        x = 10'd640;
        @(negedge clk);
        n_checks++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL disp_col20: got %b expected 000", rgb); end
        x = 10'd100; y = 10'd480;
        @(negedge clk);
        n_checks++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL disp_row15: got %b expected 000", rgb); end
        x = 10'd128; y = 10'd70;
        @(negedge clk);
        n_checks++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL disp_neighbour: got %b expected 000", rgb); end
        x = 10'd96; y = 10'd64;
        @(negedge clk);
        n_checks++; if (rgb !== corner_exp) begin n_fail++; $display("FAIL disp_cell_corner: got %b expected %b", rgb, corner_exp); end
    endtask

    task automatic test_collisions();
        int pulses;
        logic [COLS-1:0] d;
        rand_grid();
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        repeat (3) @(negedge clk);
        step = 1'b1; wr_en = 1'b1; wr_row = 5'd3; wr_data = ~mw[3];
        @(negedge clk);
        step = 1'b0; wr_en = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        model_step();
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL coll_done_pulses: got %0d expected 1", pulses); end
        n_checks++; if (gen_count !== exp_gen) begin n_fail++; $display("FAIL coll_gen: got %0d expected %0d", gen_count, exp_gen); end
        scan();
        for (int r = 0; r < ROWS; r++) begin
            n_checks++; if (sw[r] !== mw[r]) begin n_fail++; $display("FAIL coll_busy_wrap row %0d: got %h expected %h", r, sw[r], mw[r]); end
            n_checks++; if (sn[r] !== mn[r]) begin n_fail++; $display("FAIL coll_busy_nowrap row %0d: got %h expected %h", r, sn[r], mn[r]); end
        end
        d = COLS'($urandom());
        @(negedge clk);
        step = 1'b1; wr_en = 1'b1; wr_row = 5'd8; wr_data = d;
        @(negedge clk);
        step = 1'b0; wr_en = 1'b0;
        mw[8] = d; mn[8] = d;
        repeat (40) @(negedge clk);
        model_step();
        scan();
        for (int r = 0; r < ROWS; r++) begin
            n_checks++; if (sw[r] !== mw[r]) begin n_fail++; $display("FAIL coll_idle_wrap row %0d: got %h expected %h", r, sw[r], mw[r]); end
            n_checks++; if (sn[r] !== mn[r]) begin n_fail++; $display("FAIL coll_idle_nowrap row %0d: got %h expected %h", r, sn[r], mn[r]); end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        rand_grid();
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        pulses = 0;
        for (int k = 0; k < 80; k++) begin
            if (done) begin
                pulses++;
                if (pulses == 1) step = 1'b1;
            end else begin
                step = 1'b0;
            end
            @(negedge clk);
        end
        step = 1'b0;
        model_step();
        model_step();
        n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
        n_checks++; if (gen_count !== exp_gen) begin n_fail++; $display("FAIL b2b_gen: got %0d expected %0d", gen_count, exp_gen); end
        scan();
        for (int r = 0; r < ROWS; r++) begin
            n_checks++; if (sw[r] !== mw[r]) begin n_fail++; $display("FAIL b2b_wrap row %0d: got %h expected %h", r, sw[r], mw[r]); end
            n_checks++; if (sn[r] !== mn[r]) begin n_fail++; $display("FAIL b2b_nowrap row %0d: got %h expected %h", r, sn[r], mn[r]); end
        end
    endtask

    task automatic test_random();
        int bc, dc, np;
        for (int it = 0; it < 3; it++) begin
            rand_grid();
            step_watch(bc, dc, np);
            n_checks++; if (gen_count_nw !== exp_gen) begin n_fail++; $display("FAIL rand_gen it %0d: got %0d expected %0d", it, gen_count_nw, exp_gen); end
            scan();
            for (int r = 0; r < ROWS; r++) begin
                n_checks++; if (sw[r] !== mw[r]) begin n_fail++; $display("FAIL rand_wrap it %0d row %0d: got %h expected %h", it, r, sw[r], mw[r]); end
                n_checks++; if (sn[r] !== mn[r]) begin n_fail++; $display("FAIL rand_nowrap it %0d row %0d: got %h expected %h", it, r, sn[r], mn[r]); end
            end
        end
    endtask

    task automatic test_reset_mid_calc();
        int pulses, busy_seen;
        logic [2:0] line_exp;
        rand_grid();
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midcalc_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midcalc_done: got %b expected 0", done); end
        n_checks++; if (gen_count !== 16'd0) begin n_fail++; $display("FAIL midcalc_gen: got %0d expected 0", gen_count); end
        @(negedge clk); rst_n = 1'b1;
        model_clear();
        pulses = 0; busy_seen = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) pulses++;
            if (busy) busy_seen++;
            @(negedge clk);
        end
        n_checks++; if (pulses != 0 || busy_seen != 0) begin
            n_fail++; $display("FAIL midcalc_quiet: got done=%0d busy=%0d expected 0/0", pulses, busy_seen);
        end
        scan();
        for (int r = 0; r < ROWS; r++) begin
            n_checks++; if (sw[r] !== '0) begin n_fail++; $display("FAIL midcalc_grid row %0d: got %h expected 0", r, sw[r]); end
        end
`ifdef LIFE_GRIDLINES_EN
        line_exp = 3'b001;
`else
        line_exp = 3'b000;
`endif
        @(negedge clk); x = 10'd32; y = 10'd40;
        @(negedge clk);
        n_checks++; if (rgb !== line_exp) begin n_fail++; $display("FAIL midcalc_gridline: got %b expected %b", rgb, line_exp); end
    endtask

    initial begin
        rst_n = 1'b0; x = '0; y = '0; wr_en = 1'b0; wr_row = '0; wr_data = '0; step = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_blinker();
        test_wrap();
        test_display();
        test_collisions();
        test_back_to_back();
        test_random();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
